// File: rtl/hazard_sched.sv
// hazard_sched
//   Issue scheduler for the decode stage. Keeps a DEPTH-entry shift register
//   of in-flight records {w, a} (stage 1 = EX ... stage DEPTH = WB). It holds
//   back the ID instruction while any source it reads is still waiting for a
//   write to reach the register file.
//
// Handshake: id_valid offers the ID instruction. issue is the acceptance
//   strobe. The instruction moves into stage 1 on the rising edge where
//   id_valid & issue are both high, and on no other edge. issue is never high
//   while stall, hold or flush is high.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   id_valid            ID holds a valid instruction
//   id_rs, id_rt        source register numbers
//   id_rs_use/rt_use    the corresponding source is actually read
//   id_wr, id_wa        instruction writes register id_wa
//   hold                downstream freeze; nothing advances
//   flush               kill ID and stages 1..FLUSH_DEPTH
//   issue, stall        combinational issue / hazard outputs
//   wb_valid, wb_addr   stage-DEPTH record (expected writeback)
//   stall_cnt           saturating count of hazard-stall cycles
module hazard_sched #(
  parameter int DEPTH       = 3,
  parameter int WB_BYPASS   = 1,
  parameter int FLUSH_DEPTH = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_use,
  input  logic        id_rt_use,
  input  logic        id_wr,
  input  logic [4:0]  id_wa,
  input  logic        hold,
  input  logic        flush,
  output logic        issue,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [15:0] stall_cnt
);

  // Stages above LIVE are already readable from the register file.
  localparam int LIVE = DEPTH - WB_BYPASS;

  logic [DEPTH:1]      ent_w;
  logic [DEPTH:1][4:0] ent_a;
  logic [DEPTH:1]      fl_w;
  logic [DEPTH:1][4:0] fl_a;
  logic [DEPTH:1]      nxt_w;
  logic [DEPTH:1][4:0] nxt_a;
  logic [15:0]         cnt;
  logic                rs_hit;
  logic                rt_hit;

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k <= LIVE && ent_w[k]) begin
        if (ent_a[k] == id_rs) rs_hit = 1'b1;
        if (ent_a[k] == id_rt) rt_hit = 1'b1;
      end
    end
    // r0 is hardwired, so reading it never depends on anything in flight.
    if (id_rs == 5'd0) rs_hit = 1'b0;
    if (id_rt == 5'd0) rt_hit = 1'b0;
  end

  assign stall = id_valid & ((id_rs_use & rs_hit) | (id_rt_use & rt_hit));
  assign issue = id_valid & ~stall & ~hold & ~flush;

  // Flush acts on the pre-shift entries; the shift then moves the bubbles on.
  always_comb begin
    fl_w = ent_w;
    fl_a = ent_a;
    for (int k = 1; k <= DEPTH; k++) begin
      if (flush && k <= FLUSH_DEPTH) begin
        fl_w[k] = 1'b0;
        fl_a[k] = 5'd0;
      end
    end
    nxt_w = fl_w;
    nxt_a = fl_a;
    if (!hold) begin
      nxt_w[1] = issue & id_wr & (id_wa != 5'd0);
      nxt_a[1] = issue ? id_wa : 5'd0;
      for (int k = 2; k <= DEPTH; k++) begin
        nxt_w[k] = fl_w[k-1];
        nxt_a[k] = fl_a[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_w <= '0;
      ent_a <= '0;
    end else begin
      ent_w <= nxt_w;
      ent_a <= nxt_a;
    end
  end

  // Only cycles where the hazard itself blocks issue are counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (stall && !hold && !flush && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign wb_valid  = ent_w[DEPTH];
  assign wb_addr   = ent_a[DEPTH];
  assign stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched. Two instances with different parameters share the
// same ID/control stimulus. Each has its own reference model, a pool of
// issued records tagged with their age in advancing edges. The driver pushes
// expected outputs into a queue every cycle, and a negedge monitor pops and
// compares them.
module tb_hazard_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_rs_use, id_rt_use, id_wr, hold, flush;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic        issue0, stall0, wb_valid0, issue1, stall1, wb_valid1;
  logic [4:0]  wb_addr0, wb_addr1;
  logic [15:0] stall_cnt0, stall_cnt1;

  hazard_sched #(.DEPTH(3), .WB_BYPASS(1), .FLUSH_DEPTH(1)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_wr(id_wr), .id_wa(id_wa),
    .hold(hold), .flush(flush), .issue(issue0), .stall(stall0),
    .wb_valid(wb_valid0), .wb_addr(wb_addr0), .stall_cnt(stall_cnt0)
  );

  hazard_sched #(.DEPTH(6), .WB_BYPASS(0), .FLUSH_DEPTH(2)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_wr(id_wr), .id_wa(id_wa),
    .hold(hold), .flush(flush), .issue(issue1), .stall(stall1),
    .wb_valid(wb_valid1), .wb_addr(wb_addr1), .stall_cnt(stall_cnt1)
  );

  // ---------------- reference model ----------------
  int         m_depth [2] = '{3, 6};
  int         m_byp   [2] = '{1, 0};
  int         m_fd    [2] = '{1, 2};
  bit         rv      [2][8];
  bit         rw      [2][8];
  logic [4:0] ra      [2][8];
  int         rage    [2][8];
  int         mcnt    [2];

  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit m_hit(int i, logic [4:0] src);
    if (src == 5'd0) return 1'b0;
    for (int j = 0; j < 8; j++)
      if (rv[i][j] && rw[i][j] && ra[i][j] == src && rage[i][j] <= m_depth[i] - m_byp[i])
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input int i, output logic [23:0] e);
    bit st, is, wv;
    logic [4:0] wa;
    st = id_valid && ((id_rs_use && m_hit(i, id_rs)) || (id_rt_use && m_hit(i, id_rt)));
    is = id_valid && !st && !hold && !flush;
    wv = 1'b0;
    wa = 5'd0;
    for (int j = 0; j < 8; j++)
      if (rv[i][j] && rage[i][j] == m_depth[i]) begin
        wv = rw[i][j];
        wa = ra[i][j];
      end
    e = {is, st, wv, wa, 16'(mcnt[i])};
    if (!rst) begin
      for (int j = 0; j < 8; j++) rv[i][j] = 1'b0;
      mcnt[i] = 0;
    end else begin
      if (st && !hold && !flush && mcnt[i] < 65535) mcnt[i]++;
      if (flush)
        for (int j = 0; j < 8; j++)
          if (rv[i][j] && rage[i][j] <= m_fd[i]) rv[i][j] = 1'b0;
      if (!hold) begin
        for (int j = 0; j < 8; j++)
          if (rv[i][j]) begin
            rage[i][j]++;
            if (rage[i][j] > m_depth[i]) rv[i][j] = 1'b0;
          end
        if (is) begin
          for (int j = 0; j < 8; j++)
            if (!rv[i][j]) begin
              rv[i][j]   = 1'b1;
              rw[i][j]   = id_wr && (id_wa != 5'd0);
              ra[i][j]   = id_wa;
              rage[i][j] = 1;
              break;
            end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [4:0] rs_, input logic [4:0] rt_,
                      input logic rsu, input logic rtu, input logic wr,
                      input logic [4:0] wa, input logic h, input logic f,
                      input logic r);
    logic [23:0] e0, e1;
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs_; id_rt = rt_; id_rs_use = rsu; id_rt_use = rtu;
    id_wr = wr; id_wa = wa; hold = h; flush = f; rst = r;
    #1;
    model_step(0, e0); exp_q0.push_back(e0);
    model_step(1, e1); exp_q1.push_back(e1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [23:0] e, g;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      g = {issue0, stall0, wb_valid0, wb_addr0, stall_cnt0};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL u0_outputs @%0t: got %h expected %h", $time, g, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      g = {issue1, stall1, wb_valid1, wb_addr1, stall_cnt1};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL u1_outputs @%0t: got %h expected %h", $time, g, e);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int nst;
    bit done;
    rst = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_use = 1'b0;
    id_rt_use = 1'b0; id_wr = 1'b0; id_wa = 5'd0; hold = 1'b0; flush = 1'b0;

    // reset
    repeat (2) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("reset_wb_valid", 16'(wb_valid0), 16'd0);
    chk("reset_stall_cnt", stall_cnt0, 16'd0);

    // dependent pair: producer r3, consumer reads r3
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    nst = 0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      if (stall0) nst++;
      if (issue0) done = 1'b1;
    end
    chk("dep_pair_issued", 16'(done), 16'd1);
    chk("dep_pair_stalls", 16'(nst), 16'd2);
    chk("dep_pair_cnt", stall_cnt0, 16'd2);

    // r0 destination
    idle(8);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("r0_stall", 16'(stall0), 16'd0);
    chk("r0_issue", 16'(issue0), 16'd1);
    idle(1);
    chk("r0_wb_valid", 16'(wb_valid0), 16'd0);

    // hold with producer r7 in stage 1
    idle(8);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      chk("hold_no_issue", 16'(issue0), 16'd0);
    end
    nst = 0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      if (stall0) nst++;
      if (issue0) done = 1'b1;
    end
    chk("hold_release_issued", 16'(done), 16'd1);
    chk("hold_release_stalls", 16'(nst), 16'd2);

    // flush kills producer r5 in stage 1
    idle(8);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("flush_no_issue", 16'(issue0), 16'd0);
    step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("flush_after_stall", 16'(stall0), 16'd0);
    chk("flush_after_issue", 16'(issue0), 16'd1);

    // reset mid-stream with three pending writes
    idle(8);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("midrst_stall", 16'(stall0), 16'd0);
    chk("midrst_issue", 16'(issue0), 16'd1);
    chk("midrst_wb_valid", 16'(wb_valid0), 16'd0);
    chk("midrst_cnt", stall_cnt0, 16'd0);

    // randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) != 0);

    // saturation: a chain of r9 read-modify-writes keeps the hazard alive
    idle(8);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 80000 && !done; c++) begin
      step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
      if (mcnt[1] == 65535) done = 1'b1;
    end
    chk("sat_reached", 16'(done), 16'd1);
    repeat (20) step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    chk("sat_cnt_u1", stall_cnt1, 16'hFFFF);

    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
